// File: rtl/mult_ate_pkg.sv
// rtl/mult_ate_pkg.sv - shared types, defaults and MISR step function for result compaction
// Contents:
//   misr_state_t   window FSM states (IDLE, ACCUM, DONE)
//   MISR_W         signature width handled by misr_step
//   DEF_MISR_POLY  default feedback taps (x^64+x^4+x^3+x+1)
//   DEF_MISR_SEED  default signature load value
//   misr_step      one MISR shift/feedback/fold step
package mult_ate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } misr_state_t;

    localparam int          MISR_W        = 64;
    localparam logic [63:0] DEF_MISR_POLY = 64'h0000_0000_0000_001B;
    localparam logic [63:0] DEF_MISR_SEED = 64'h0;

    // Shift left, fold in the taps when the bit falling off the top is set,
    // then XOR in the incoming result beat.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] data,
        input logic [MISR_W-1:0] poly = DEF_MISR_POLY
    );
        return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - multiple-input signature register with seed load and step enable
// Ports:
//   clk, rst   clock, asynchronous active-high reset (reset loads the seed)
//   load       reload MISR_SEED (wins over en)
//   en         perform one MISR step with data
//   data       beat folded in on a step
//   sig        registered signature
//   sig_next   signature that a step this cycle would produce
module misr_reg
    import mult_ate_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] MISR_POLY = DEF_MISR_POLY,
    parameter logic [DATA_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sig,
    output logic [DATA_W-1:0] sig_next
);

    assign sig_next = misr_step(sig, data, MISR_POLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/mult_result_misr.sv
// rtl/mult_result_misr.sv - compacts a window of multiplier results into a MISR and checks it against golden
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_in, result_in multiplier result stream (no backpressure)
//   start               pulse: reseed, latch win_len/golden, open window
//   win_len, golden     window length in valid beats, expected final signature
//   ack                 leaves DONE for IDLE
//   busy, done          window in progress / window complete
//   pass                final signature matched golden (valid while done)
//   overrun             sticky: a beat arrived while in DONE
//   signature, count    current MISR contents, beats compacted this window
module mult_result_misr
    import mult_ate_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] MISR_POLY = DEF_MISR_POLY,
    parameter logic [DATA_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              start,
    input  logic [CNT_W-1:0]  win_len,
    input  logic [DATA_W-1:0] golden,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              overrun,
    output logic [DATA_W-1:0] signature,
    output logic [CNT_W-1:0]  count
);

    misr_state_t       state;
    logic [CNT_W-1:0]  win_len_q;
    logic [DATA_W-1:0] golden_q;
    logic [DATA_W-1:0] sig_next;
    logic [CNT_W-1:0]  count_inc;
    logic              step_en;

    // A beat coinciding with start belongs to no window and is dropped.
    assign step_en   = (state == ST_ACCUM) && valid_in && !start;
    assign count_inc = count + 1'b1;

    misr_reg #(
        .DATA_W    (DATA_W),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .en       (step_en),
        .data     (result_in),
        .sig      (signature),
        .sig_next (sig_next)
    );

    // busy/done are kept as their own flops so every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            win_len_q <= '0;
            golden_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            overrun   <= 1'b0;
        end else if (start) begin
            count     <= '0;
            overrun   <= 1'b0;
            win_len_q <= win_len;
            golden_q  <= golden;
            if (win_len != '0) begin
                state <= ST_ACCUM;
                busy  <= 1'b1;
                done  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                // Empty window: the seed itself is the final signature.
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (MISR_SEED == golden);
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (valid_in) begin
                        count <= count_inc;
                        if (count_inc == win_len_q) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == golden_q);
                        end
                    end
                end
                ST_DONE: begin
                    if (valid_in) begin
                        overrun <= 1'b1;
                    end
                    if (ack) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mult_result_misr.md
# mult_result_misr

Downstream test-compaction stage for `pipelined_multiplier`. It consumes the multiplier's `valid_out`/`result` stream and folds a programmable window of results into a 64-bit multiple-input signature register (MISR). At window end it compares the signature against a golden value, giving ATE patterns a single pass/fail and signature instead of per-vector result strobes.

## Interface
- `DATA_W`, 64: result width; equals multiplier `result` width.
- `CNT_W`, 16: width of window length and beat counter.
- `MISR_POLY`, 64'h0000_0000_0000_001B: feedback taps (x^64+x^4+x^3+x+1).
- `MISR_SEED`, 64'h0: signature load value at start.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_in`  in  1  result beat valid; driven by multiplier `valid_out`.
- `result_in`  in  DATA_W  result beat; driven by multiplier `result`.
- `start`  in  1  single-cycle pulse: load seed, latch `win_len` and `golden`, begin window.
- `win_len`  in  CNT_W  number of valid beats to compact.
- `golden`  in  DATA_W  expected final signature.
- `ack`  in  1  clears DONE and returns to IDLE.
- `busy`  out  1  high in ACCUM.
- `done`  out  1  high in DONE.
- `pass`  out  1  final signature == golden; meaningful while `done`.
- `overrun`  out  1  sticky: valid beat arrived while in DONE.
- `signature`  out  DATA_W  current MISR contents.
- `count`  out  CNT_W  valid beats compacted in current window.

## Operation
- States: IDLE, ACCUM, DONE. Reset: IDLE, `signature`=MISR_SEED, `count`=0, `busy`=`done`=`pass`=`overrun`=0.
- MISR step: `sig_next = {sig[62:0],1'b0} ^ (sig[63] ? MISR_POLY : 0) ^ result_in`.
- `start` (any state, highest priority): `signature`←MISR_SEED, `count`←0, `overrun`←0, `pass`←0, latch `win_len`/`golden`. `win_len`≠0 → ACCUM; `win_len`==0 → DONE, with `pass`=(MISR_SEED==golden). A `valid_in` beat on the `start` cycle is not compacted.
- ACCUM: each cycle with `valid_in`=1 performs one MISR step and `count`+1; `valid_in`=0 cycles (bubbles) change nothing. On the beat where `count`+1 == latched `win_len`: → DONE and `pass`←(`sig_next`==latched golden), all on the same edge.
- DONE: `signature`/`count`/`pass` held. Valid beats are ignored and set `overrun`. `ack` → IDLE (signature held, `done`=0). `start`+`ack` in the same cycle: `start` wins.
- IDLE: valid beats ignored, no flag; `ack` ignored.
- `count` never wraps: window end is reached at `win_len` ≤ 2^CNT_W−1.

## Timing
- All outputs registered, direct from flops.
- `busy` rises the cycle after `start`.
- `done`/`pass` are visible in the cycle after the final accepted beat's edge; zero bubble cycles are needed between windows (`start` may coincide with DONE).
- Throughput: one beat per clock, no backpressure; the upstream multiplier cannot stall.
- Asserting `rst` mid-window forces reset values immediately, without waiting for a clock edge. The first `start` after deassertion behaves normally.

## Structure
- Package `mult_ate_pkg`: `misr_state_t` enum (IDLE, ACCUM, DONE), default `MISR_POLY`/`MISR_SEED` constants, function `misr_step(sig, data)`.
- Sub-module `misr_reg`: signature register with `load` (seed) and `en` (step) inputs. The top level holds the FSM, counter, golden latch and flags.

## Test plan
- `start`, `win_len`=0, `golden`=0 → next cycle `done`=1, `pass`=1, `count`=0, `signature`=0; `ack` → `done`=0.
- `win_len`=2, `golden`=64'hFFFF_FFFF_FFFF_FFE5, beats 64'hFFFF_FFFF_FFFF_FFFF then 64'h0 → after beat 1 `signature`=all-ones; `done`=1, `pass`=1, `count`=2.
- Same window with bubbles: beats as above, `valid_in` low 3 cycles between them → identical signature and `pass`; `done` is delayed by exactly 3 cycles.
- `win_len`=1, beat 64'h0000_0000_8000_0000, then a second beat in DONE → `signature`=64'h8000_0000; `overrun`=1; next `start` clears `overrun`.
- Restart: `win_len`=4; after 2 beats pulse `start` with `win_len`=1 → `count`=0, signature reloads seed, window ends after 1 further beat.
- Assert `rst` mid-ACCUM with no clock edge → all outputs at reset values immediately; a subsequent full window produces the correct signature.
